// File: rtl/xpb_pkg.sv
// -----------------------------------------------------------------------------
// xpb_pkg
// Shared definitions for the XPB helpers: default datapath sizes, the table
// generator state encoding and the table depth function.
// -----------------------------------------------------------------------------
package xpb_pkg;

   localparam int WORD_W_DEF = 1024;
   localparam int IDX_W_DEF  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GEN   = 2'd1,
      READY = 2'd2
   } state_t;

   // Number of table entries addressed by an idx_w-bit digit segment.
   function automatic int depth(input int idx_w);
      return 1 << idx_w;
   endfunction

endpackage

// File: rtl/xpb_modadd.sv
// -----------------------------------------------------------------------------
// xpb_modadd
// Combinational modular adder: y = (a + b) mod n.
// The result is only meaningful when a < n and b < n; then a + b < 2n, so a
// single conditional subtract is enough.
//
// Ports:
//   a, b  in  WORD_W  operands, each < n
//   n     in  WORD_W  modulus
//   y     out WORD_W  (a + b) mod n
// -----------------------------------------------------------------------------
module xpb_modadd #(
   parameter int WORD_W = 1024
) (
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] n,
   output logic [WORD_W-1:0] y
);

   // One extra bit so the carry out of a + b is kept for the compare.
   logic [WORD_W:0] sum;
   logic [WORD_W:0] diff;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = sum - {1'b0, n};
      if (sum >= {1'b0, n}) begin
         y = diff[WORD_W-1:0];
      end else begin
         y = sum[WORD_W-1:0];
      end
   end

endmodule

// File: rtl/xpb_lut_gen.sv
// -----------------------------------------------------------------------------
// xpb_lut_gen
// Builds the table j*B mod N (j = 0 .. 2^IDX_W-1) at runtime by repeated
// modular addition, then serves registered single-cycle lookups.
//
// Ports:
//   clk         in   1       clock
//   reset       in   1       asynchronous, active-high
//   start       in   1       one-cycle request to (re)generate the table
//   base_in     in   WORD_W  B, sampled with start
//   modulus_in  in   WORD_W  N, sampled with start
//   busy        out  1       generation in progress
//   ready       out  1       table valid, lookups allowed
//   cfg_err     out  1       sticky: last start was rejected (N == 0 or B >= N)
//   rd_en       in   1       lookup request
//   idx_in      in   IDX_W   lookup index
//   data_out    out  WORD_W  table[idx_in], registered
//   data_valid  out  1       data_out updated this cycle
//   rd_err      out  1       one-cycle pulse: rd_en seen while not ready
//   dbg_state   out  2       current state (IDLE/GEN/READY encoding)
//
// Handshake: a lookup is a single-cycle request with no back-pressure. rd_en
// sampled high at an edge while ready is high returns table[idx_in] after that
// edge with data_valid high for exactly one cycle; rd_en while ready is low is
// dropped and answered with a one-cycle rd_err. start is likewise a one-cycle
// request, accepted in IDLE/READY and ignored in GEN.
// -----------------------------------------------------------------------------
module xpb_lut_gen
   import xpb_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] base_in,
   input  logic [WORD_W-1:0] modulus_in,
   output logic              busy,
   output logic              ready,
   output logic              cfg_err,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  idx_in,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid,
   output logic              rd_err,
   output logic [1:0]        dbg_state
);

   localparam int             DEPTH = depth(IDX_W);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   state_t            state, state_next;
   logic [WORD_W-1:0] b_q, n_q, acc, nxt;
   logic [IDX_W-1:0]  cnt;
   logic              cfg_ok;
   logic              start_acc;
   logic              start_rej;

   logic              we;
   logic [IDX_W-1:0]  waddr;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] mem [DEPTH];

   assign cfg_ok = (modulus_in != '0) && (base_in < modulus_in);

   // busy/ready are pure decodes of the state register, so they are glitch-free
   // and both 0 in reset (IDLE).
   assign busy      = (state == GEN);
   assign ready     = (state == READY);
   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start_acc  = 1'b0;
      start_rej  = 1'b0;
      case (state)
         IDLE, READY: begin
            if (start) begin
               if (cfg_ok) begin
                  start_acc  = 1'b1;
                  state_next = GEN;
               end else begin
                  // Rejected: table and state stay as they were.
                  start_rej = 1'b1;
               end
            end
         end
         GEN: begin
            if (cnt == LAST) begin
               state_next = READY;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Generation datapath: acc walks through j*B mod N, one entry per cycle.
   // ---------------------------------------------------------------------------
   xpb_modadd #(.WORD_W(WORD_W)) u_modadd (
      .a (acc),
      .b (b_q),
      .n (n_q),
      .y (nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_err <= 1'b0;
         b_q     <= '0;
         n_q     <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         if (start_acc) begin
            cfg_err <= 1'b0;
            b_q     <= base_in;
            n_q     <= modulus_in;
            acc     <= '0;
            cnt     <= IDX_W'(1);
         end else if (start_rej) begin
            cfg_err <= 1'b1;
         end
         if (state == GEN) begin
            acc <= nxt;
            cnt <= cnt + IDX_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Table storage. Entry 0 is written on the accepted start edge, entry cnt
   // on each GEN edge. Not reset: ready=0 keeps stale contents unreadable.
   // ---------------------------------------------------------------------------
   always_comb begin
      we    = start_acc || (state == GEN);
      waddr = start_acc ? '0 : cnt;
      wdata = start_acc ? '0 : nxt;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port. A lookup on the same edge as an accepted start
   // still sees ready=1 and reads the old contents (writes land after the edge).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         rd_err     <= 1'b0;
         if (rd_en) begin
            if (ready) begin
               data_out   <= mem[idx_in];
               data_valid <= 1'b1;
            end else begin
               rd_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_xpb_lut_gen.sv
// -----------------------------------------------------------------------------
// tb_xpb_lut_gen
// Two instances: a small one (WORD_W=8, IDX_W=3) for hand-computed tables and
// the default-size one (WORD_W=1024, IDX_W=5) checked against j*B mod N.
// -----------------------------------------------------------------------------
module tb_xpb_lut_gen;
   import xpb_pkg::*;

   localparam int W8 = 8;
   localparam int I8 = 3;
   localparam int WK = 1024;
   localparam int IK = 5;

   logic clk;
   logic reset;

   // small instance
   logic          s8_start, s8_rd_en;
   logic [W8-1:0] s8_base, s8_mod, s8_dout;
   logic [I8-1:0] s8_idx;
   logic          s8_busy, s8_ready, s8_cfg_err, s8_dv, s8_rd_err;
   logic [1:0]    s8_dbg;

   // default-size instance
   logic          sk_start, sk_rd_en;
   logic [WK-1:0] sk_base, sk_mod, sk_dout;
   logic [IK-1:0] sk_idx;
   logic          sk_busy, sk_ready, sk_cfg_err, sk_dv, sk_rd_err;
   logic [1:0]    sk_dbg;

   int checks   = 0;
   int failures = 0;

   logic [WK-1:0] n_k, b_k, b_k2;
   logic [WK-1:0] exp_q[$];

   xpb_lut_gen #(.WORD_W(W8), .IDX_W(I8)) u_s8 (
      .clk        (clk),
      .reset      (reset),
      .start      (s8_start),
      .base_in    (s8_base),
      .modulus_in (s8_mod),
      .busy       (s8_busy),
      .ready      (s8_ready),
      .cfg_err    (s8_cfg_err),
      .rd_en      (s8_rd_en),
      .idx_in     (s8_idx),
      .data_out   (s8_dout),
      .data_valid (s8_dv),
      .rd_err     (s8_rd_err),
      .dbg_state  (s8_dbg)
   );

   xpb_lut_gen #(.WORD_W(WK), .IDX_W(IK)) u_sk (
      .clk        (clk),
      .reset      (reset),
      .start      (sk_start),
      .base_in    (sk_base),
      .modulus_in (sk_mod),
      .busy       (sk_busy),
      .ready      (sk_ready),
      .cfg_err    (sk_cfg_err),
      .rd_en      (sk_rd_en),
      .idx_in     (sk_idx),
      .data_out   (sk_dout),
      .data_valid (sk_dv),
      .rd_err     (sk_rd_err),
      .dbg_state  (sk_dbg)
   );

   // ---------------------------------------------------------------------------
   // clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge; inputs are driven and outputs sampled 1 after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // checker (prints low 512 bits so the line stays short)
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [WK-1:0] obs, input logic [WK-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, obs[511:0], exp[511:0]);
      end
   endtask

   // ---------------------------------------------------------------------------
   // driver tasks
   // ---------------------------------------------------------------------------
   task automatic lookup8(input int idx, input int exp);
      s8_rd_en = 1'b1;
      s8_idx   = I8'(idx);
      tick();
      s8_rd_en = 1'b0;
      check($sformatf("s8_dv[%0d]", idx), WK'(s8_dv), WK'(1));
      check($sformatf("s8_data[%0d]", idx), WK'(s8_dout), WK'(exp));
   endtask

   task automatic start8(input int b, input int n);
      s8_start = 1'b1;
      s8_base  = W8'(b);
      s8_mod   = W8'(n);
      tick();
      s8_start = 1'b0;
   endtask

   // Start a full-size generation, count busy cycles until ready (bounded).
   task automatic gen_k(input logic [WK-1:0] b, input logic [WK-1:0] n);
      int busy_cnt;
      sk_start = 1'b1;
      sk_base  = b;
      sk_mod   = n;
      tick();
      sk_start = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40 && !sk_ready; i++) begin
         if (sk_busy) busy_cnt++;
         tick();
      end
      check("sk_ready_after_gen", WK'(sk_ready), WK'(1));
      check("sk_busy_cycles", WK'(busy_cnt), WK'(31));
   endtask

   // Scoreboard: queue expected j*B mod N from a multiply/modulo model,
   // then read every entry and pop.
   task automatic verify_k(input logic [WK-1:0] b, input logic [WK-1:0] n);
      logic [WK+7:0] prod;
      logic [WK-1:0] exp;
      for (int j = 0; j < 32; j++) begin
         prod = (WK+8)'(j) * {8'd0, b};
         prod = prod % {8'd0, n};
         exp_q.push_back(prod[WK-1:0]);
      end
      for (int j = 0; j < 32; j++) begin
         sk_rd_en = 1'b1;
         sk_idx   = IK'(j);
         tick();
         sk_rd_en = 1'b0;
         exp = exp_q.pop_front();
         check($sformatf("sk_dv[%0d]", j), WK'(sk_dv), WK'(1));
         check($sformatf("sk_data[%0d]", j), sk_dout, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int tbl_a[8];
      int tbl_b[8];
      tbl_a = '{0, 3, 6, 2, 5, 1, 4, 0};
      tbl_b = '{0, 5, 3, 1, 6, 4, 2, 0};

      reset    = 1'b1;
      s8_start = 1'b0; s8_rd_en = 1'b0; s8_base = '0; s8_mod = '0; s8_idx = '0;
      sk_start = 1'b0; sk_rd_en = 1'b0; sk_base = '0; sk_mod = '0; sk_idx = '0;
      n_k  = {32{32'hF00D_1235}};
      b_k  = {32{32'h1234_5677}};
      b_k2 = n_k - WK'(1);

      tick(); tick();
      reset = 1'b0;
      tick();

      // reset state
      check("rst_busy",  WK'(s8_busy),    WK'(0));
      check("rst_ready", WK'(s8_ready),   WK'(0));
      check("rst_cfg",   WK'(s8_cfg_err), WK'(0));
      check("rst_dv",    WK'(s8_dv),      WK'(0));
      check("rst_rderr", WK'(s8_rd_err),  WK'(0));
      check("rst_data",  WK'(s8_dout),    WK'(0));
      check("rst_state", WK'(s8_dbg),     WK'(IDLE));

      // rd_en while idle
      s8_rd_en = 1'b1; s8_idx = 3'd2;
      tick();
      s8_rd_en = 1'b0;
      check("idle_rderr", WK'(s8_rd_err), WK'(1));
      check("idle_dv",    WK'(s8_dv),     WK'(0));

      // N=7, B=3 with a lookup and an (invalid) start injected mid-GEN
      start8(3, 7);                                     // edge T0
      check("gen_busy_t0",  WK'(s8_busy),  WK'(1));
      check("gen_ready_t0", WK'(s8_ready), WK'(0));
      check("gen_state",    WK'(s8_dbg),   WK'(GEN));
      check("gen_rderr_clr", WK'(s8_rd_err), WK'(0));
      tick(); tick();                                   // T0+1, T0+2
      s8_rd_en = 1'b1; s8_idx = 3'd1;
      s8_start = 1'b1; s8_mod = '0; s8_base = '0;
      tick();                                           // T0+3
      s8_rd_en = 1'b0; s8_start = 1'b0;
      check("gen_rderr",     WK'(s8_rd_err),  WK'(1));
      check("gen_rd_dv",     WK'(s8_dv),      WK'(0));
      check("gen_rd_data",   WK'(s8_dout),    WK'(0));
      check("gen_start_cfg", WK'(s8_cfg_err), WK'(0));
      check("gen_start_busy", WK'(s8_busy),   WK'(1));
      tick();                                           // T0+4
      check("gen_rderr_pulse", WK'(s8_rd_err), WK'(0));
      tick(); tick();                                   // T0+5, T0+6
      check("gen_busy_t6",  WK'(s8_busy),  WK'(1));
      check("gen_ready_t6", WK'(s8_ready), WK'(0));
      tick();                                           // T0+7
      check("gen_busy_t7",  WK'(s8_busy),  WK'(0));
      check("gen_ready_t7", WK'(s8_ready), WK'(1));
      for (int j = 0; j < 8; j++) lookup8(j, tbl_a[j]);
      tick();
      check("dv_drop", WK'(s8_dv), WK'(0));
      check("data_hold", WK'(s8_dout), WK'(0));

      // rejected configurations: B == N, then N == 0
      start8(7, 7);
      check("cfg_bn_err",   WK'(s8_cfg_err), WK'(1));
      check("cfg_bn_ready", WK'(s8_ready),   WK'(1));
      lookup8(2, 6);
      start8(0, 0);
      check("cfg_n0_err",   WK'(s8_cfg_err), WK'(1));
      check("cfg_n0_ready", WK'(s8_ready),   WK'(1));
      lookup8(5, 1);

      // valid start B=5 together with a lookup of idx 2 (served from old table)
      s8_rd_en = 1'b1; s8_idx = 3'd2;
      start8(5, 7);
      s8_rd_en = 1'b0;
      check("swap_data",  WK'(s8_dout),    WK'(6));
      check("swap_dv",    WK'(s8_dv),      WK'(1));
      check("swap_ready", WK'(s8_ready),   WK'(0));
      check("swap_cfg",   WK'(s8_cfg_err), WK'(0));
      check("swap_busy",  WK'(s8_busy),    WK'(1));
      for (int i = 0; i < 7; i++) tick();
      check("swap_ready_after", WK'(s8_ready), WK'(1));
      for (int j = 0; j < 8; j++) lookup8(j, tbl_b[j]);

      // full-size table
      gen_k(b_k, n_k);
      verify_k(b_k, n_k);

      // reset at T0+10 during a full-size generation
      sk_start = 1'b1; sk_base = b_k2; sk_mod = n_k;
      tick();                                           // T0
      sk_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();              // T0+10
      reset = 1'b1;
      #1;
      check("mid_rst_busy",  WK'(sk_busy),  WK'(0));
      check("mid_rst_ready", WK'(sk_ready), WK'(0));
      check("mid_rst_cfg",   WK'(sk_cfg_err), WK'(0));
      check("mid_rst_data",  sk_dout,       WK'(0));
      check("mid_rst_state", WK'(sk_dbg),   WK'(IDLE));
      tick();
      reset = 1'b0;
      tick();
      sk_rd_en = 1'b1; sk_idx = 5'd3;
      tick();
      sk_rd_en = 1'b0;
      check("post_rst_rderr", WK'(sk_rd_err), WK'(1));
      check("post_rst_dv",    WK'(sk_dv),     WK'(0));

      // restart after reset with B = N-1
      gen_k(b_k2, n_k);
      verify_k(b_k2, n_k);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
